// File: rtl/issue_rat_pkg.sv
// Shared types and constants for the rename free-list controller.
// The PRF space is split into two banks by index parity.
package issue_rat_pkg;

  localparam int PRF_WIDTH  = 6;
  localparam int PRF_COUNT  = 64;
  localparam int BANK_COUNT = 2;

  typedef logic [PRF_WIDTH-1:0] prf_t;

  // Bank 0 holds the even PRFs and bank 1 holds the odd PRFs.
  function automatic logic prf_bank(input prf_t p);
    return p[0];
  endfunction

endpackage

// File: rtl/issue_rat_freelist_skid.sv
// One-entry holding buffer for abandoned PRFs that could not go straight
// into their bank.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   capture         load capture_prf into the buffer (wins over drain)
//   capture_prf     PRF to hold
//   drain           the held PRF is being written to its bank this cycle
//   buf_valid       buffer holds a PRF
//   buf_prf         held PRF
module issue_rat_freelist_skid
  import issue_rat_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic capture,
  input  prf_t capture_prf,
  input  logic drain,
  output logic buf_valid,
  output prf_t buf_prf
);

  logic buf_valid_q;
  prf_t buf_q;

  // A capture in the same cycle as a drain refills the buffer, so the
  // valid flag stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
    end else if (capture) begin
      buf_valid_q <= 1'b1;
    end else if (drain) begin
      buf_valid_q <= 1'b0;
    end
  end

  // The data register needs no reset: it is only observed when valid.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= capture_prf;
    end
  end

  assign buf_valid = buf_valid_q;
  assign buf_prf   = buf_q;

endmodule

// File: rtl/issue_rat_freelist_ctrl.sv
// Two-bank PRF free-list controller. Released PRFs (redeemed at commit,
// abandoned at rollback) are steered to the bank given by their low bit,
// acquires are round-robined across the banks, and the authoritative free
// count (banks plus skid buffer) is kept here.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   i_redeemed_*/o_redeemed_ready   commit release handshake
//   i_abandoned_*/o_abandoned_ready rollback release handshake
//   o_acquire_*/i_acquire_ready     rename allocation handshake
//   o_bank_din/wen/ren          write data/enables and read enables per bank
//   i_bank_dout/empty/full      FWFT head and status per bank
//   o_free_count                free PRFs held
//   o_almost_empty              free count at or below ALMOST_EMPTY_THRESH
module issue_rat_freelist_ctrl #(
  parameter int PRF_WIDTH           = 6,
  parameter int COUNT_WIDTH         = 7,
  parameter int RESET_FREE_COUNT    = 64,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRF_WIDTH-1:0]      i_redeemed_prf,
  input  logic                      i_redeemed_valid,
  output logic                      o_redeemed_ready,
  input  logic [PRF_WIDTH-1:0]      i_abandoned_prf,
  input  logic                      i_abandoned_valid,
  output logic                      o_abandoned_ready,
  output logic [PRF_WIDTH-1:0]      o_acquire_prf,
  output logic                      o_acquire_valid,
  input  logic                      i_acquire_ready,
  output logic [1:0][PRF_WIDTH-1:0] o_bank_din,
  output logic [1:0]                o_bank_wen,
  output logic [1:0]                o_bank_ren,
  input  logic [1:0][PRF_WIDTH-1:0] i_bank_dout,
  input  logic [1:0]                i_bank_empty,
  input  logic [1:0]                i_bank_full,
  output logic [COUNT_WIDTH-1:0]    o_free_count,
  output logic                      o_almost_empty
);

  import issue_rat_pkg::*;

  logic                   r_bank, a_bank, b_bank;
  logic                   r_fire, a_fire, a_direct, a_capture;
  logic                   drain_b;
  logic                   buf_valid;
  prf_t                   buf_prf;
  logic                   rr_q, sel, acq_fire;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [1:0][PRF_WIDTH-1:0] din;
  logic [1:0]             wen, ren;

  // ---- release steering: redeem > skid buffer > abandon input ----
  assign r_bank = prf_bank(i_redeemed_prf);
  assign a_bank = prf_bank(i_abandoned_prf);
  assign b_bank = prf_bank(buf_prf);

  assign o_redeemed_ready = ~i_bank_full[r_bank];
  assign r_fire           = i_redeemed_valid & o_redeemed_ready;

  assign drain_b = buf_valid & ~(r_fire & (r_bank == b_bank)) & ~i_bank_full[b_bank];

  // Abandon readiness depends only on buffer state, never on its own valid.
  assign o_abandoned_ready = ~buf_valid | drain_b;
  assign a_fire            = i_abandoned_valid & o_abandoned_ready;
  // Direct only with an empty buffer, so an abandon never overtakes one held.
  assign a_direct  = a_fire & ~buf_valid & ~(r_fire & (r_bank == a_bank))
                   & ~i_bank_full[a_bank];
  assign a_capture = a_fire & ~a_direct;

  issue_rat_freelist_skid u_skid (
    .clk         (clk),
    .reset       (reset),
    .capture     (a_capture),
    .capture_prf (i_abandoned_prf),
    .drain       (drain_b),
    .buf_valid   (buf_valid),
    .buf_prf     (buf_prf)
  );

  // The three sources are mutually exclusive per bank by construction.
  always_comb begin
    wen = '0;
    din = '0;
    if (r_fire) begin
      wen[r_bank] = 1'b1;
      din[r_bank] = i_redeemed_prf;
    end
    if (drain_b) begin
      wen[b_bank] = 1'b1;
      din[b_bank] = buf_prf;
    end
    if (a_direct) begin
      wen[a_bank] = 1'b1;
      din[a_bank] = i_abandoned_prf;
    end
  end

  // ---- acquire: round-robin with fallback to the non-empty bank ----
  assign sel             = i_bank_empty[rr_q] ? ~rr_q : rr_q;
  assign o_acquire_valid = ~&i_bank_empty;
  assign o_acquire_prf   = i_bank_dout[sel];
  assign acq_fire        = o_acquire_valid & i_acquire_ready;

  always_comb begin
    ren      = '0;
    ren[sel] = acq_fire;
  end

  // Banks reset alongside this block, so no enable may leak out during reset.
  assign o_bank_din = din;
  assign o_bank_wen = wen & {2{reset}};
  assign o_bank_ren = ren & {2{reset}};

  // ---- state: round-robin pointer and free count ----
  // A drain from the buffer is count-neutral: it was counted on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q    <= 1'b0;
      count_q <= COUNT_WIDTH'(RESET_FREE_COUNT);
    end else begin
      if (acq_fire) begin
        rr_q <= ~sel;
      end
      count_q <= count_q + COUNT_WIDTH'(r_fire) + COUNT_WIDTH'(a_fire)
               - COUNT_WIDTH'(acq_fire);
    end
  end

  assign o_free_count   = count_q;
  assign o_almost_empty = (count_q <= COUNT_WIDTH'(ALMOST_EMPTY_THRESH));

  // Underflow would wrap above the reset value, so one bound covers both ends.
  count_in_range: assert property (@(posedge clk) disable iff (!reset)
    count_q <= COUNT_WIDTH'(RESET_FREE_COUNT));

endmodule

// File: tb/tb_issue_rat_freelist_ctrl.sv
module tb_issue_rat_freelist_ctrl;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [5:0]      i_redeemed_prf = '0;
  logic            i_redeemed_valid = 1'b0;
  logic            o_redeemed_ready;
  logic [5:0]      i_abandoned_prf = '0;
  logic            i_abandoned_valid = 1'b0;
  logic            o_abandoned_ready;
  logic [5:0]      o_acquire_prf;
  logic            o_acquire_valid;
  logic            i_acquire_ready = 1'b0;
  logic [1:0][5:0] o_bank_din;
  logic [1:0]      o_bank_wen;
  logic [1:0]      o_bank_ren;
  logic [1:0][5:0] i_bank_dout;
  logic [1:0]      i_bank_empty;
  logic [1:0]      i_bank_full;
  logic [6:0]      o_free_count;
  logic            o_almost_empty;

  int errors = 0;
  int checks = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  issue_rat_freelist_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .i_redeemed_prf    (i_redeemed_prf),
    .i_redeemed_valid  (i_redeemed_valid),
    .o_redeemed_ready  (o_redeemed_ready),
    .i_abandoned_prf   (i_abandoned_prf),
    .i_abandoned_valid (i_abandoned_valid),
    .o_abandoned_ready (o_abandoned_ready),
    .o_acquire_prf     (o_acquire_prf),
    .o_acquire_valid   (o_acquire_valid),
    .i_acquire_ready   (i_acquire_ready),
    .o_bank_din        (o_bank_din),
    .o_bank_wen        (o_bank_wen),
    .o_bank_ren        (o_bank_ren),
    .i_bank_dout       (i_bank_dout),
    .i_bank_empty      (i_bank_empty),
    .i_bank_full       (i_bank_full),
    .o_free_count      (o_free_count),
    .o_almost_empty    (o_almost_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural FWFT banks, 32 deep, reset full with their parity's PRFs.
  logic [5:0] mem [2][32];
  int rp[2], wp[2], cnt[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 32; i++) mem[b][i] <= 6'(2*i + b);
        rp[b]  <= 0;
        wp[b]  <= 0;
        cnt[b] <= 32;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (o_bank_wen[b]) begin
          mem[b][wp[b]] <= o_bank_din[b];
          wp[b] <= (wp[b] + 1) % 32;
        end
        if (o_bank_ren[b]) rp[b] <= (rp[b] + 1) % 32;
        cnt[b] <= cnt[b] + int'(o_bank_wen[b]) - int'(o_bank_ren[b]);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      i_bank_dout[b]  = mem[b][rp[b]];
      i_bank_empty[b] = (cnt[b] == 0);
      i_bank_full[b]  = (cnt[b] == 32);
    end
  end

  // Acquire scoreboard and bank protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (o_acquire_valid && i_acquire_ready) begin
        if (sb.size() == 0) check("acq_extra", 32'(sb.size()), 1);
        else check("acq_prf", {26'd0, o_acquire_prf}, {26'd0, sb.pop_front()});
      end
      for (int b = 0; b < 2; b++) begin
        if (o_bank_wen[b]) check("wr_into_full", {31'd0, i_bank_full[b]}, 0);
        if (o_bank_ren[b]) check("rd_from_empty", {31'd0, i_bank_empty[b]}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_count", o_free_count, 64);
    check("rst_wen", o_bank_wen, 0);
    check("rst_ren", o_bank_ren, 0);
    check("rst_aready", o_abandoned_ready, 1);
    check("rst_almost", o_almost_empty, 0);
    step(); step();
    reset = 1'b1;

    // 64 back-to-back acquires in strict alternation.
    for (int i = 0; i < 64; i++) sb.push_back(6'(i));
    i_acquire_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("drain_count", o_free_count, 32'(64 - i));
      check("drain_almost", o_almost_empty, (64 - i) <= 4);
      step();
    end
    check("drain_count_end", o_free_count, 0);
    check("drain_valid_end", o_acquire_valid, 0);
    check("drain_almost_end", o_almost_empty, 1);
    check("drain_sb", 32'(sb.size()), 0);
    i_acquire_ready = 1'b0;

    // Redeem and abandon to different banks both go direct.
    i_redeemed_prf = 6'd6;  i_redeemed_valid = 1'b1;
    i_abandoned_prf = 6'd9; i_abandoned_valid = 1'b1;
    #1;
    check("diff_rready", o_redeemed_ready, 1);
    check("diff_aready", o_abandoned_ready, 1);
    check("diff_wen", o_bank_wen, 2'b11);
    check("diff_din0", o_bank_din[0], 6);
    check("diff_din1", o_bank_din[1], 9);
    step();
    i_redeemed_valid = 1'b0; i_abandoned_valid = 1'b0;
    check("diff_count", o_free_count, 2);
    sb.push_back(6'd6); sb.push_back(6'd9);
    i_acquire_ready = 1'b1;
    step(); step();
    i_acquire_ready = 1'b0;
    check("diff_sb", 32'(sb.size()), 0);
    check("diff_count_end", o_free_count, 0);

    // Same-bank contention: redeem writes, abandon is buffered then drains.
    i_redeemed_prf = 6'd4;  i_redeemed_valid = 1'b1;
    i_abandoned_prf = 6'd8; i_abandoned_valid = 1'b1;
    #1;
    check("same_aready", o_abandoned_ready, 1);
    check("same_wen", o_bank_wen, 2'b01);
    check("same_din0", o_bank_din[0], 4);
    step();
    i_redeemed_valid = 1'b0; i_abandoned_valid = 1'b0;
    #1;
    check("same_count_cap", o_free_count, 2);
    check("same_drain_wen", o_bank_wen, 2'b01);
    check("same_drain_din0", o_bank_din[0], 8);
    step();
    check("same_count", o_free_count, 2);
    sb.push_back(6'd4); sb.push_back(6'd8);
    i_acquire_ready = 1'b1;
    step(); step();
    i_acquire_ready = 1'b0;
    check("same_sb", 32'(sb.size()), 0);

    // Busy buffer blocks abandon while redeem keeps claiming the bank.
    i_redeemed_prf = 6'd12;  i_redeemed_valid = 1'b1;
    i_abandoned_prf = 6'd10; i_abandoned_valid = 1'b1;
    step();
    i_redeemed_prf = 6'd16;
    i_abandoned_prf = 6'd14;
    #1;
    check("busy_aready", o_abandoned_ready, 0);
    check("busy_wen", o_bank_wen, 2'b01);
    check("busy_din0", o_bank_din[0], 16);
    step();
    i_redeemed_valid = 1'b0;
    #1;
    check("busy_aready_back", o_abandoned_ready, 1);
    check("busy_drain_din0", o_bank_din[0], 10);
    step();
    i_abandoned_valid = 1'b0;
    #1;
    check("busy_drain2_din0", o_bank_din[0], 14);
    step();
    check("busy_count", o_free_count, 4);
    sb.push_back(6'd12); sb.push_back(6'd16); sb.push_back(6'd10); sb.push_back(6'd14);
    i_acquire_ready = 1'b1;
    repeat (4) step();
    i_acquire_ready = 1'b0;
    check("busy_sb", 32'(sb.size()), 0);
    check("busy_count_end", o_free_count, 0);

    // Fill bank 1, then a redeem to it must be refused until space frees.
    for (int k = 0; k < 32; k++) begin
      i_redeemed_prf = 6'(2*k + 1); i_redeemed_valid = 1'b1;
      step();
    end
    i_redeemed_prf = 6'd63;
    #1;
    check("full_rready", o_redeemed_ready, 0);
    check("full_wen", o_bank_wen, 0);
    check("full_count", o_free_count, 32);
    sb.push_back(6'd1);
    i_acquire_ready = 1'b1;
    step();
    i_acquire_ready = 1'b0;
    #1;
    check("full_rready_back", o_redeemed_ready, 1);
    check("full_wen_back", o_bank_wen, 2'b10);
    check("full_din1", o_bank_din[1], 63);
    step();
    i_redeemed_valid = 1'b0;
    check("full_count_end", o_free_count, 32);
    check("full_sb", 32'(sb.size()), 0);

    // Build up a held buffer entry with count 37, then reset mid-operation.
    i_redeemed_prf = 6'd20;  i_redeemed_valid = 1'b1;
    i_abandoned_prf = 6'd22; i_abandoned_valid = 1'b1;
    step();
    i_abandoned_valid = 1'b0;
    i_redeemed_prf = 6'd24; step();
    #1;
    check("hold_aready", o_abandoned_ready, 0);
    i_redeemed_prf = 6'd26; step();
    i_redeemed_prf = 6'd28; step();
    i_redeemed_valid = 1'b0;
    #1;
    check("hold_count", o_free_count, 37);
    check("hold_wen", o_bank_wen, 2'b01);
    check("hold_din0", o_bank_din[0], 22);
    reset = 1'b0;
    #1;
    check("mid_rst_count", o_free_count, 64);
    check("mid_rst_aready", o_abandoned_ready, 1);
    check("mid_rst_wen", o_bank_wen, 0);
    check("mid_rst_ren", o_bank_ren, 0);
    step(); step();
    reset = 1'b1;
    sb.push_back(6'd0);
    i_acquire_ready = 1'b1;
    step();
    i_acquire_ready = 1'b0;
    check("post_rst_count", o_free_count, 63);
    check("post_rst_sb", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/issue_rat_freelist_ctrl.md
Name: issue_rat_freelist_ctrl

Overview:
Controller for the two-bank PRF free list. There are 64 PRFs; bank 0 holds even PRFs and bank 1 holds odd PRFs, each bank a 32-deep 1w1r FIFO. The block steers released PRFs (redeemed at commit, abandoned at rollback) into the correct bank, owns the one-entry abandoned skid buffer, round-robins acquires across the banks for the rename stage, and keeps the authoritative free count.

Parameters:
PRF_WIDTH, 6, PRF index width; bit 0 selects the bank.
COUNT_WIDTH, 7, free-count width (range 0..64).
RESET_FREE_COUNT, 64, free count after reset (both banks reset full).
ALMOST_EMPTY_THRESH, 4, o_almost_empty asserts when free count <= this value.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_redeemed_prf  in  6  PRF released at commit
i_redeemed_valid  in  1  redeem request
o_redeemed_ready  out  1  redeem accepted
i_abandoned_prf  in  6  PRF released on rollback
i_abandoned_valid  in  1  abandon request
o_abandoned_ready  out  1  abandon accepted
o_acquire_prf  out  6  next free PRF
o_acquire_valid  out  1  a free PRF is available
i_acquire_ready  in  1  rename consumes o_acquire_prf
o_bank_din  out  2x6  write data to bank 0 / bank 1
o_bank_wen  out  2  write enables
o_bank_ren  out  2  read enables
i_bank_dout  in  2x6  FWFT head of each bank
i_bank_empty  in  2  bank empty flags
i_bank_full  in  2  bank full flags
o_free_count  out  7  free PRFs held (banks plus skid buffer)
o_almost_empty  out  1  free_count <= ALMOST_EMPTY_THRESH

Behaviour:
- Reset (async assert, sync deassert): buf_valid_q=0, rr_q=0 (prefer bank 0), count_q=64. All bank enables are 0 during reset. Banks share the same reset.
- Bank of a PRF p is p[0].
- Release priority per cycle: redeem (R) > skid buffer (B) > abandon input (A). Each bank takes at most one write per cycle.
- o_redeemed_ready = ~i_bank_full[i_redeemed_prf[0]]. On R handshake, write bank[i_redeemed_prf[0]] in the same cycle.
- drain_b = buf_valid_q, AND the buffer's bank is not claimed by R, AND that bank is not full. When drain_b is true, write buf_q to its bank.
- A goes direct when: ~buf_valid_q, AND bank not claimed by R, AND bank not full.
- Otherwise A is captured into the buffer if ~buf_valid_q or drain_b.
- o_abandoned_ready = ~buf_valid_q | drain_b. It must not depend on i_abandoned_valid.
- A never bypasses B, so abandon order is preserved.
- Acquire: sel = rr_q if ~i_bank_empty[rr_q], else ~rr_q.
  - o_acquire_valid = ~&i_bank_empty; o_acquire_prf = i_bank_dout[sel].
  - On handshake: o_bank_ren[sel]=1, and rr_q <= ~sel.
  - With no handshake, rr_q holds.
- Read and write to the same bank in one cycle is legal (1w1r).
- Count: count_q <= count_q + (#direct writes from R and A) + (A captured) − (acquire handshake).
  - A drain from B is count-neutral (already counted on capture).
  - Saturation is impossible by construction; simulation asserts 0 <= count_q <= 64.
- Latency: release to visible at the bank head is 1 cycle (FIFO write). Capture to buffer drain is >= 1 cycle.
- Redeem and abandon targeting the same bank in one cycle: R writes, A goes to the buffer (or stalls if the buffer is busy and not draining).
- Both banks empty: o_acquire_valid=0, and a same-cycle release does not bypass to acquire.
- Reset mid-operation: a buffered PRF is discarded, which is correct because the banks reload full.

Decomposition:
- Package issue_rat_pkg holds:
  - PRF_WIDTH, PRF_COUNT=64, BANK_COUNT=2
  - prf_t typedef
  - function prf_bank(prf_t) returning bit 0
- One sub-module, issue_rat_freelist_skid: the 1-entry abandon buffer, with valid/data regs, capture, and drain.

Test Plan:
- Reset, then 64 back-to-back acquires with ready=1 → PRFs 0,1,2,...,63 in strict alternation. count goes 64→0; valid drops on cycle 65; o_almost_empty from count=4.
- Drain all, then redeem 6 and abandon 9 in the same cycle → both written direct (different banks). count=2. Next acquires return 6 then 9.
- Drain all, then redeem 4 and abandon 8 in the same cycle → R written, 8 buffered, o_abandoned_ready=1. Next cycle: 8 drains, count=2, order 4 then 8 preserved in bank 0.
- Buffer holds 10 (bank 0 contended by redeem 12), then abandon 14 arrives while redeem 16 also hits bank 0 → o_abandoned_ready=0. Ready returns once 10 drains.
- Bank 1 full and redeem 63 → o_redeemed_ready=0 and no write. Acquire one odd PRF → ready rises next cycle.
- Assert reset low with buf_valid_q=1 and count=37 → buf_valid_q=0, count=64, rr=0 immediately (asynchronous). First acquire after release returns 0.
